apb_timer_slave: RTL
====================

# apb_timer_slave

APB2 responder holding a 32-bit down-counting timer with prescaler, reload, and interrupt. It sits on the APB side of the AHB-to-APB bridge and occupies one of the bridge's three PSEL lines. Software programs and reads it through ordinary APB transfers. It provides the system tick and timeout source.

## Interface
- PRESC_W, default 8: prescaler register and counter width, 1..16.
- HCLK, input, 1: single clock, shared with the bridge's APB side.
- HRESETn, input, 1: asynchronous active-low reset.
- PSEL, input, 1: select, driven by one bit of the bridge's PSEL[2:0].
- PENABLE, input, 1: access-phase marker.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, 32: byte address; only [4:2] decoded.
- PWDATA, input, 32: write data.
- PRDATA, output, 32: read data, registered; drives 0 when not returning a read, so slaves can be OR-combined.
- TIMER_IRQ, output, 1: level interrupt, equal to STATUS.PEND & CTRL.IRQ_EN.

## Operation
- APB2 protocol: no PREADY, no PSLVERR, zero wait states.
  - Setup phase is PSEL=1, PENABLE=0.
  - Access phase is PSEL=1, PENABLE=1.
- Register map (PADDR[4:2]):
  - 0 CTRL: [0] EN, [1] IRQ_EN, [2] ONESHOT. Other bits read 0.
  - 1 LOAD: reload value. Writing it also copies the value into VALUE and clears the prescaler count.
  - 2 VALUE: current count, read-only; writes ignored.
  - 3 PRESC: divide value [PRESC_W-1:0]. Writing it clears the prescaler count.
  - 4 STATUS: [0] PEND, write-1-to-clear.
  - 5–7: read 0, writes ignored.
- Timer FSM:
  - States: STOP, RUN. Reset state is STOP.
  - STOP→RUN on a committed CTRL write with EN=1.
  - RUN→STOP on a committed CTRL write with EN=0, or on a one-shot expiry.
- Prescaler:
  - In RUN, count pc runs 0..PRESC; pc==PRESC produces a tick and pc←0.
  - In STOP, pc is held at 0.
- On a tick:
  - If VALUE≠0: VALUE←VALUE−1.
  - If VALUE==0 (expiry): PEND←1. If ONESHOT, EN←0, state←STOP, VALUE stays 0; otherwise VALUE←LOAD.
- Periodic expiry interval is (LOAD+1)·(PRESC+1) cycles.
- LOAD=0 gives an expiry on every tick.

## Timing
- Write commit: register updates on the HCLK edge ending the access phase (PSEL&PENABLE&PWRITE). The new value is visible the next cycle.
- Read:
  - PRDATA is loaded on the edge ending the setup phase (PSEL&!PENABLE&!PWRITE) and held through the access phase.
  - On every other edge, PRDATA←0.
  - The value returned is the register content at the end of setup.
- TIMER_IRQ rises one cycle after the expiry edge. It falls one cycle after a PEND clear or an IRQ_EN clear.
- First expiry after enable: (VALUE+1)·(PRESC+1) cycles after the EN commit edge.
- Simultaneous events:
  - PEND set by expiry and STATUS W1C on the same edge: set wins.
  - CTRL write EN=0 and tick on the same edge: write wins, tick discarded.
  - LOAD write and tick on the same edge: load wins, no decrement.
  - PRESC write and tick on the same edge: write wins, pc←0.
- Reset values: PRDATA=0, TIMER_IRQ=0, CTRL=0, LOAD=0, VALUE=0, PRESC=0, PEND=0, pc=0, state STOP.
- Reset asserted mid-transfer clears all of the above immediately. The in-flight access is dropped.

## Configuration
- APB_TIMER_ONESHOT_EN defined: CTRL[2] is implemented, and one-shot mode behaves as above.
- APB_TIMER_ONESHOT_EN undefined:
  - CTRL[2] is not stored and reads 0.
  - The timer is always periodic.
  - The RUN→STOP expiry transition is absent.

## Structure
- Shared package apb_timer_pkg holds:
  - Register offsets (CTRL/LOAD/VALUE/PRESC/STATUS).
  - CTRL bit positions.
  - STOP/RUN state encoding.
- One sub-module, apb_timer_prescaler. It holds pc, compares against PRESC, outputs tick, and takes run and clear inputs.
- Register decode, FSM, and the counter stay in apb_timer_slave.

## Test plan
- Reset: assert HRESETn=0 mid-write. Response: PRDATA=0, TIMER_IRQ=0; all registers then read 0, and VALUE stays 0 with no ticks.
- Register access:
  - Write LOAD=0x0000_0005 and read back LOAD: 0x5.
  - Read VALUE: 0x5.
  - Read offset 6: 0x0, and PRDATA=0 outside reads.
- Periodic mode: LOAD=3, PRESC=0, CTRL=0x3. Response: TIMER_IRQ rises 5 cycles after the EN commit, and PEND re-asserts every 4 cycles after each W1C clear.
- Prescaler: LOAD=1, PRESC=4, CTRL=0x1. Response: VALUE decrements every 5 cycles, and PEND sets 10 cycles after enable.
- One-shot mode (macro on): LOAD=2, CTRL=0x7. Response: one expiry, then CTRL reads 0x6, VALUE=0, and no further PEND after a clear. With the macro off, CTRL reads 0x3 and expiries repeat.
- Collision: STATUS W1C committed on the same edge as an expiry. Response: PEND reads 1 and TIMER_IRQ stays high.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets, CTRL/STATUS bit positions and timer FSM
// state encoding shared by the APB timer slave and its prescaler.
package apb_timer_pkg;

  // Word offsets decoded from PADDR[4:2]
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_LOAD   = 3'd1;
  localparam logic [2:0] ADDR_VALUE  = 3'd2;
  localparam logic [2:0] ADDR_PRESC  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_ONESHOT_BIT = 2;

  // STATUS register bit positions
  localparam int STATUS_PEND_BIT = 0;

  // Timer run state
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: divides the clock by (presc+1) while running.
// The count is held at zero when stopped and restarts from zero on clear.
// A clear on the same cycle as a would-be tick suppresses that tick.
module apb_timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc_q;
  logic [PRESC_W-1:0] pc_d;

  // Next count and tick: wrap to zero and pulse tick when the count reaches presc
  always_comb begin
    tick = 1'b0;
    pc_d = pc_q;
    if (!run || clear) begin
      pc_d = '0;
    end else if (pc_q == presc) begin
      tick = 1'b1;
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB2 responder with a 32-bit down-counting timer,
// prescaler, reload value and level interrupt.
// Optional feature macro: APB_TIMER_ONESHOT_EN enables CTRL[2] (one-shot
// mode). Without it the ONESHOT bit is never set, reads 0, and the timer
// is always periodic.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        TIMER_IRQ
);

`ifdef APB_TIMER_ONESHOT_EN
  localparam logic ONESHOT_IMPL = 1'b1;
`else
  localparam logic ONESHOT_IMPL = 1'b0;
`endif

  timer_state_e       state_q, state_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic               ctrl_irq_en_q, ctrl_irq_en_d;
  logic               ctrl_oneshot_q, ctrl_oneshot_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        value_q, value_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pend_q, pend_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               irq_q, irq_d;

  logic [2:0]  reg_addr;
  logic        wr_commit, rd_setup;
  logic        wr_ctrl, wr_load, wr_presc, wr_status;
  logic        tick, tick_eff, expiry, oneshot_expiry;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign reg_addr  = PADDR[4:2];
  assign wr_commit = PSEL & PENABLE & PWRITE;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign wr_ctrl   = wr_commit & (reg_addr == ADDR_CTRL);
  assign wr_load   = wr_commit & (reg_addr == ADDR_LOAD);
  assign wr_presc  = wr_commit & (reg_addr == ADDR_PRESC);
  assign wr_status = wr_commit & (reg_addr == ADDR_STATUS);

  assign unused_addr_bits = ^{PADDR[31:5], PADDR[1:0]};

  // A stopping CTRL write or a LOAD write on the tick edge swallows the tick
  assign tick_eff       = tick & ~(wr_ctrl & ~PWDATA[CTRL_EN_BIT]) & ~wr_load;
  assign expiry         = tick_eff & (value_q == 32'd0);
  assign oneshot_expiry = expiry & ctrl_oneshot_q;
  assign irq_d          = pend_q & ctrl_irq_en_q;

  apb_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .run   (state_q == ST_RUN),
    .clear (wr_load | wr_presc),
    .presc (presc_q),
    .tick  (tick)
  );

  // Timer FSM next state: CTRL writes start/stop, a one-shot expiry stops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (wr_ctrl && PWDATA[CTRL_EN_BIT]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_ctrl) begin
          if (!PWDATA[CTRL_EN_BIT]) state_d = ST_STOP;
        end else if (oneshot_expiry) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Register writes, counter update and pending flag; later assignments win
  always_comb begin
    ctrl_en_d      = ctrl_en_q;
    ctrl_irq_en_d  = ctrl_irq_en_q;
    ctrl_oneshot_d = ctrl_oneshot_q;
    load_d         = load_q;
    value_d        = value_q;
    presc_d        = presc_q;
    pend_d         = pend_q;

    if (tick_eff) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else if (!ctrl_oneshot_q) begin
        value_d = load_q;
      end
    end

    if (wr_load) begin
      load_d  = PWDATA;
      value_d = PWDATA;
    end

    if (wr_presc) presc_d = PWDATA[PRESC_W-1:0];

    if (wr_ctrl) begin
      ctrl_en_d      = PWDATA[CTRL_EN_BIT];
      ctrl_irq_en_d  = PWDATA[CTRL_IRQ_EN_BIT];
      ctrl_oneshot_d = ONESHOT_IMPL & PWDATA[CTRL_ONESHOT_BIT];
    end else if (oneshot_expiry) begin
      ctrl_en_d = 1'b0;
    end

    if (wr_status && PWDATA[STATUS_PEND_BIT]) pend_d = 1'b0;
    if (expiry) pend_d = 1'b1;
  end

  // Read data: captured at the end of a read setup phase, zero otherwise
  always_comb begin
    rdata = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        rdata[CTRL_EN_BIT]      = ctrl_en_q;
        rdata[CTRL_IRQ_EN_BIT]  = ctrl_irq_en_q;
        rdata[CTRL_ONESHOT_BIT] = ctrl_oneshot_q;
      end
      ADDR_LOAD:   rdata = load_q;
      ADDR_VALUE:  rdata = value_q;
      ADDR_PRESC:  rdata = {{(32 - PRESC_W){1'b0}}, presc_q};
      ADDR_STATUS: rdata[STATUS_PEND_BIT] = pend_q;
      default:     rdata = '0;
    endcase
    prdata_d = rd_setup ? rdata : 32'd0;
  end

  // All state registers, cleared asynchronously by HRESETn
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= ST_STOP;
      ctrl_en_q      <= 1'b0;
      ctrl_irq_en_q  <= 1'b0;
      ctrl_oneshot_q <= 1'b0;
      load_q         <= '0;
      value_q        <= '0;
      presc_q        <= '0;
      pend_q         <= 1'b0;
      prdata_q       <= '0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctrl_en_q      <= ctrl_en_d;
      ctrl_irq_en_q  <= ctrl_irq_en_d;
      ctrl_oneshot_q <= ctrl_oneshot_d;
      load_q         <= load_d;
      value_q        <= value_d;
      presc_q        <= presc_d;
      pend_q         <= pend_d;
      prdata_q       <= prdata_d;
      irq_q          <= irq_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign TIMER_IRQ = irq_q;

endmodule
